// File: rtl/uart_rx_fifo_less_pkg.sv
// Shared UART receive constants, FSM state encoding and small helpers.
package uart_rx_fifo_less_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    function automatic int tick_div(input int sys_clk_freq, input int baud_rate);
        return sys_clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_less_baud_tick.sv
// Oversample tick generator: one-cycle pulse every SYS_CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
module uart_baud_tick
    import uart_rx_fifo_less_pkg::*;
#(
    parameter int BAUD_RATE    = 9600,
    parameter int SYS_CLK_FREQ = 12000000,
    parameter int OVERSAMPLE_P = OVERSAMPLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE_P);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = !restart && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick)
            cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_fifo_less.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit decisions and a
// single-entry valid/ready output that flags framing errors and overruns.
module uart_rx_fifo_less
    import uart_rx_fifo_less_pkg::*;
#(
    parameter int BAUD_RATE    = 9600,
    parameter int SYS_CLK_FREQ = 12000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       is_receiving,
    output logic       recv_error,
    output logic       overrun
);

    rx_state_e  state_q, state_d;
    logic [1:0] sync_q;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       ovr_q, ovr_d;

    logic rxs, tick, restart, maj, decide, wrap, deliver;

    assign rxs     = sync_q[1];
    assign restart = (state_q == ST_IDLE);

    uart_baud_tick #(
        .BAUD_RATE    (BAUD_RATE),
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .OVERSAMPLE_P (OVERSAMPLE)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // Third vote is the live sample taken at the decision tick itself.
    assign maj    = maj3(samp_q[0], samp_q[1], rxs);
    assign decide = tick && (tcnt_q == 4'(SAMPLE_HI));
    assign wrap   = tick && (tcnt_q == 4'(OVERSAMPLE - 1));

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        samp_d   = samp_q;
        byte_d   = byte_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        deliver  = 1'b0;

        if (tick) begin
            tcnt_d = tcnt_q + 4'd1;
            if (tcnt_q == 4'(SAMPLE_LO))  samp_d[0] = rxs;
            if (tcnt_q == 4'(SAMPLE_MID)) samp_d[1] = rxs;
        end

        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (decide && maj) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    state_d  = ST_DATA;
                    bitcnt_d = '0;
                end
            end
            ST_DATA: begin
                if (decide) shreg_d = {maj, shreg_q[7:1]};
                if (wrap) begin
                    if (bitcnt_q == 3'(DATA_BITS - 1)) state_d  = ST_STOP;
                    else                               bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (maj) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold here until the line recovers so a stuck-low rx cannot re-arm.
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (deliver) begin
            if (!valid_q || rx_ready) begin
                byte_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            state_q  <= ST_IDLE;
            tcnt_q   <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            samp_q   <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], rx};
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            samp_q   <= samp_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_byte      = byte_q;
    assign rx_valid     = valid_q;
    assign recv_error   = err_q;
    assign overrun      = ovr_q;
    assign is_receiving = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_less.sv
// Scoreboard bench for uart_rx_fifo_less: directed frames, monitor pops expected bytes on handshakes.
module tb_uart_rx_fifo_less;

    // TICK_DIV = 12e6 / (187500*16) = 4 clocks -> 64 clocks per bit
    localparam int SYS     = 12000000;
    localparam int BAUD    = 187500;
    localparam int CLK_P   = 10;
    localparam int BIT_NOM = 64 * CLK_P;
    localparam int BIT_FST = 627;
    localparam int BIT_SLW = 653;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_valid, is_receiving, recv_error, overrun;

    int checks = 0;
    int errors = 0;
    int n_hs = 0;
    int n_err = 0;
    int n_ovr = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo_less #(.BAUD_RATE(BAUD), .SYS_CLK_FREQ(SYS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .is_receiving (is_receiving),
        .recv_error   (recv_error),
        .overrun      (overrun)
    );

    always #(CLK_P/2) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts flag pulses and checks every handshaked byte against the queue.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (rst_n) begin
            if (recv_error) n_err++;
            if (overrun)    n_ovr++;
            if (rx_valid && rx_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", rx_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_byte_hs", 32'(rx_byte), 32'(e));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int bit_t, input logic stop_v, input int spike_i);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == spike_i) begin
                #(360);
                rx = ~b[i];
                #(30);
                rx = b[i];
                #(bit_t - 390);
            end else begin
                #(bit_t);
            end
        end
        rx = stop_v;
        #(bit_t);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        rx_ready = v;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] msg [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                             8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    int bit_set [3] = '{BIT_NOM, BIT_FST, BIT_SLW};

    initial begin
        // Reset state
        wait_clks(4);
        chk("rst_rx_valid",     32'(rx_valid), 0);
        chk("rst_rx_byte",      32'(rx_byte), 0);
        chk("rst_is_receiving", 32'(is_receiving), 0);
        chk("rst_recv_error",   32'(recv_error), 0);
        chk("rst_overrun",      32'(overrun), 0);
        rst_n = 1'b1;
        wait_clks(20);

        // Single frame, consumer stalled
        exp_q.push_back(8'h48);
        fork
            send(8'h48, BIT_NOM, 1'b1, -1);
            begin
                #(BIT_NOM * 4);
                chk("mid_frame_receiving", 32'(is_receiving), 1);
            end
        join
        wait_clks(3);
        chk("single_valid",     32'(rx_valid), 1);
        chk("single_byte",      32'(rx_byte), 32'h48);
        chk("single_receiving", 32'(is_receiving), 0);
        chk("single_err_cnt",   n_err, 0);
        set_ready(1'b1);
        wait_clks(3);
        chk("single_hs_cnt",   n_hs, 1);
        chk("single_valid_clr", 32'(rx_valid), 0);

        // Back-to-back stream at nominal, -2% and +2% bit times
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 12; i++) begin
                exp_q.push_back(msg[i]);
                send(msg[i], bit_set[k], 1'b1, -1);
            end
            wait_clks(10);
            chk("stream_hs_cnt", n_hs, 1 + 12 * (k + 1));
            chk("stream_ovr_cnt", n_ovr, 0);
            chk("stream_err_cnt", n_err, 0);
            wait_clks(30);
        end

        // Framing error, line held low, then a good frame
        send(8'h55, BIT_NOM, 1'b0, -1);
        #(BIT_NOM);
        chk("break_receiving", 32'(is_receiving), 1);
        #(BIT_NOM);
        rx = 1'b1;
        #(BIT_NOM * 2);
        chk("frame_err_cnt",   n_err, 1);
        chk("frame_valid",     32'(rx_valid), 0);
        chk("frame_receiving", 32'(is_receiving), 0);
        chk("frame_hs_cnt",    n_hs, 37);
        exp_q.push_back(8'h6C);
        send(8'h6C, BIT_NOM, 1'b1, -1);
        wait_clks(10);
        chk("after_break_hs_cnt", n_hs, 38);

        // Short low glitch on idle line
        rx = 1'b0;
        #(12 * CLK_P);
        rx = 1'b1;
        wait_clks(120);
        chk("glitch_receiving", 32'(is_receiving), 0);
        chk("glitch_err_cnt",   n_err, 1);
        chk("glitch_hs_cnt",    n_hs, 38);

        // One-tick spike on the middle sample of data bit 3
        exp_q.push_back(8'hA5);
        send(8'hA5, BIT_NOM, 1'b1, 3);
        wait_clks(10);
        chk("spike_hs_cnt", n_hs, 39);

        // Overrun with consumer stalled
        set_ready(1'b0);
        exp_q.push_back(8'h11);
        send(8'h11, BIT_NOM, 1'b1, -1);
        send(8'h22, BIT_NOM, 1'b1, -1);
        wait_clks(10);
        chk("ovr_byte",  32'(rx_byte), 32'h11);
        chk("ovr_valid", 32'(rx_valid), 1);
        chk("ovr_cnt",   n_ovr, 1);
        set_ready(1'b1);
        wait_clks(3);
        chk("ovr_valid_clr", 32'(rx_valid), 0);
        chk("ovr_hs_cnt",    n_hs, 40);
        set_ready(1'b0);
        send(8'h33, BIT_NOM, 1'b1, -1);
        wait_clks(10);
        chk("after_ovr_byte",  32'(rx_byte), 32'h33);
        chk("after_ovr_valid", 32'(rx_valid), 1);
        chk("after_ovr_cnt",   n_ovr, 1);

        // Reset in the middle of data bit 4, held until the frame has passed
        fork
            send(8'h6F, BIT_NOM, 1'b1, -1);
            begin
                #(BIT_NOM * 5 + 300);
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                chk("midrst_valid",     32'(rx_valid), 0);
                chk("midrst_byte",      32'(rx_byte), 0);
                chk("midrst_receiving", 32'(is_receiving), 0);
                chk("midrst_err",       32'(recv_error), 0);
                chk("midrst_ovr",       32'(overrun), 0);
            end
        join
        #(BIT_NOM * 2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ready(1'b1);
        wait_clks(10);
        exp_q.push_back(8'h21);
        send(8'h21, BIT_NOM, 1'b1, -1);
        wait_clks(10);
        chk("post_rst_hs_cnt",  n_hs, 41);
        chk("post_rst_err_cnt", n_err, 1);

        // Drain: every expected byte must have been seen
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
            @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
